// File: rtl/bus_timer_if.sv
// Word-access bus between the bridge and a bus_timer instance, plus the timer's irq line.
interface bus_timer_if;
  logic [1:0]  addr;
  logic        we;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        irq;

  modport master (
    output addr,
    output we,
    output wdata,
    input  rdata,
    input  irq
  );

  modport slave (
    input  addr,
    input  we,
    input  wdata,
    output rdata,
    output irq
  );
endinterface

// File: rtl/bus_timer.sv
// Memory-mapped countdown timer: CTRL/PRESET/COUNT window, one-shot or auto-reload, masked irq.
// A bus write always wins over the FSM step scheduled for the same edge.
module bus_timer #(
  parameter int CNT_W = 32
) (
  input  logic         clk,
  input  logic         reset,
  bus_timer_if.slave   bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CNT  = 2'd2,
    ST_INT  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(32'd1);

  state_t           state_r;
  state_t           state_nxt_s;
  logic             en_r;
  logic             en_nxt_s;
  logic [1:0]       mode_r;
  logic [1:0]       mode_nxt_s;
  logic             im_r;
  logic             im_nxt_s;
  logic [CNT_W-1:0] preset_r;
  logic [CNT_W-1:0] preset_nxt_s;
  logic [CNT_W-1:0] count_r;
  logic [CNT_W-1:0] count_nxt_s;
  logic             flag_r;
  logic             flag_nxt_s;

  // State and register file update
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r  <= ST_IDLE;
      en_r     <= 1'b0;
      mode_r   <= 2'd0;
      im_r     <= 1'b0;
      preset_r <= CNT_ZERO;
      count_r  <= CNT_ZERO;
      flag_r   <= 1'b0;
    end else begin
      state_r  <= state_nxt_s;
      en_r     <= en_nxt_s;
      mode_r   <= mode_nxt_s;
      im_r     <= im_nxt_s;
      preset_r <= preset_nxt_s;
      count_r  <= count_nxt_s;
      flag_r   <= flag_nxt_s;
    end
  end

  // Next-state: a write cycle updates registers only; otherwise the FSM takes one step
  always_comb begin
    state_nxt_s  = state_r;
    en_nxt_s     = en_r;
    mode_nxt_s   = mode_r;
    im_nxt_s     = im_r;
    preset_nxt_s = preset_r;
    count_nxt_s  = count_r;
    flag_nxt_s   = flag_r;

    if (bus.we) begin
      case (bus.addr)
        2'd0: begin
          en_nxt_s    = bus.wdata[0];
          mode_nxt_s  = bus.wdata[2:1];
          im_nxt_s    = bus.wdata[3];
          state_nxt_s = ST_IDLE;
          flag_nxt_s  = 1'b0;
        end
        2'd1: begin
          preset_nxt_s = bus.wdata[CNT_W-1:0];
        end
        default: begin
          state_nxt_s = state_r;
        end
      endcase
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (en_r) begin
            state_nxt_s = ST_LOAD;
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end
        ST_LOAD: begin
          count_nxt_s = preset_r;
          flag_nxt_s  = 1'b0;
          state_nxt_s = ST_CNT;
        end
        ST_CNT: begin
          if (!en_r) begin
            state_nxt_s = ST_IDLE;
          end else if (count_r > CNT_ONE) begin
            count_nxt_s = count_r - CNT_ONE;
          end else begin
            // Covers PRESET=0 too: it expires exactly like PRESET=1
            count_nxt_s = CNT_ZERO;
            flag_nxt_s  = 1'b1;
            state_nxt_s = ST_INT;
          end
        end
        ST_INT: begin
          if (mode_r == 2'd1) begin
            flag_nxt_s = 1'b0;
          end else begin
            en_nxt_s = 1'b0;
          end
          state_nxt_s = ST_IDLE;
        end
        default: begin
          state_nxt_s = ST_IDLE;
        end
      endcase
    end
  end

  // Read mux, combinational from addr
  always_comb begin
    bus.rdata = 32'd0;
    case (bus.addr)
      2'd0:    bus.rdata = {28'd0, im_r, mode_r, en_r};
      2'd1:    bus.rdata = 32'(preset_r);
      2'd2:    bus.rdata = 32'(count_r);
      default: bus.rdata = 32'd0;
    endcase
  end

  assign bus.irq = flag_r & im_r;

endmodule
